// File: rtl/regfile_pkg.sv
// Shared types and helpers for the multi-port register file.
package regfile_pkg;

  localparam int RF_DATA_W = 32;
  localparam int RF_ADDR_W = 5;
  // Widest entry the parity helper accepts; narrower data is zero-extended.
  localparam int RF_MAX_W  = 64;

  typedef enum logic {
    RF_INIT = 1'b0,
    RF_RUN  = 1'b1
  } rf_state_e;

  // Even-parity bit: makes the total count of ones (data + bit) even.
  function automatic logic even_parity(input logic [RF_MAX_W-1:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/regfile_clear_fsm.sv
// Sequential clear engine: walks every entry after reset or clear_i, then enters RUN.
module regfile_clear_fsm
  import regfile_pkg::*;
#(
  parameter int ADDR_W = RF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear_i,
  output rf_state_e         state_o,
  output logic              clr_we_o,
  output logic [ADDR_W-1:0] clr_addr_o,
  output logic              ready_o
);

  rf_state_e         state_q;
  logic [ADDR_W-1:0] clr_ptr_q;
  logic              ready_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= RF_INIT;
      clr_ptr_q <= '0;
      ready_q   <= 1'b0;
    end else begin
      case (state_q)
        RF_INIT: begin
          // Pointer wraps back to 0 on the same edge that clears the last entry.
          clr_ptr_q <= clr_ptr_q + 1'b1;
          if (clr_ptr_q == '1) begin
            state_q <= RF_RUN;
            ready_q <= 1'b1;
          end
        end
        RF_RUN: begin
          if (clear_i) begin
            state_q   <= RF_INIT;
            clr_ptr_q <= '0;
            ready_q   <= 1'b0;
          end
        end
        default: begin
          state_q   <= RF_INIT;
          clr_ptr_q <= '0;
          ready_q   <= 1'b0;
        end
      endcase
    end
  end

  assign state_o    = state_q;
  assign clr_we_o   = (state_q == RF_INIT) && !rst;
  assign clr_addr_o = clr_ptr_q;
  assign ready_o    = ready_q;

endmodule

// File: rtl/regfile_mp.sv
// Parametrised multi-read-port register file with zero register, bypass and clear engine.
// Optional per-entry parity checking is enabled by defining REGFILE_PARITY_EN.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int DATA_W   = RF_DATA_W,
  parameter int ADDR_W   = RF_ADDR_W,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clear_i,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr_i,
  output logic [NUM_RD*DATA_W-1:0] rd_data_o,
  output logic [NUM_RD-1:0]        rd_perr_o,
  input  logic                     wr_en_i,
  input  logic [ADDR_W-1:0]        wr_addr_i,
  input  logic [DATA_W-1:0]        wr_data_i,
  output logic                     ready_o,
  output logic [7:0]               led_o
);

  localparam int DEPTH = 2 ** ADDR_W;
`ifdef REGFILE_PARITY_EN
  localparam int MEM_W = DATA_W + 1;
`else
  localparam int MEM_W = DATA_W;
`endif

  rf_state_e         state;
  logic              clr_we;
  logic [ADDR_W-1:0] clr_addr;
  logic              wr_acc;
  logic [MEM_W-1:0]  wr_word;
  logic [MEM_W-1:0]  mem_q [DEPTH];
  logic [7:0]        led_q;

  regfile_clear_fsm #(
    .ADDR_W(ADDR_W)
  ) u_clr (
    .clk       (clk),
    .rst       (rst),
    .clear_i   (clear_i),
    .state_o   (state),
    .clr_we_o  (clr_we),
    .clr_addr_o(clr_addr),
    .ready_o   (ready_o)
  );

  // A write counts only in RUN, outside reset/clear, and never to a hardwired zero entry.
  assign wr_acc = (state == RF_RUN) && !clear_i && !rst && wr_en_i &&
                  !((ZERO_REG != 0) && (wr_addr_i == '0));

`ifdef REGFILE_PARITY_EN
  assign wr_word = {even_parity(RF_MAX_W'(wr_data_i)), wr_data_i};
`else
  assign wr_word = wr_data_i;
`endif

  always_ff @(posedge clk) begin
    if (clr_we) begin
      mem_q[clr_addr] <= '0;
    end else if (wr_acc) begin
      mem_q[wr_addr_i] <= wr_word;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      led_q <= '0;
    end else if (wr_acc) begin
      led_q <= wr_data_i[7:0];
    end
  end

  assign led_o = led_q;

  for (genvar gi = 0; gi < NUM_RD; gi++) begin : g_rd
    logic [ADDR_W-1:0] addr;
    logic [MEM_W-1:0]  word;
    logic [DATA_W-1:0] data;
    logic              perr;

    assign addr = rd_addr_i[gi*ADDR_W +: ADDR_W];
    assign word = mem_q[addr];

    always_comb begin
      data = '0;
      perr = 1'b0;
      if (state == RF_RUN) begin
        if ((ZERO_REG != 0) && (addr == '0)) begin
          data = '0;
        end else if ((BYPASS != 0) && wr_acc && (wr_addr_i == addr)) begin
          data = wr_data_i;
        end else begin
          data = word[DATA_W-1:0];
`ifdef REGFILE_PARITY_EN
          perr = word[DATA_W] != even_parity(RF_MAX_W'(word[DATA_W-1:0]));
`endif
        end
      end
    end

    assign rd_data_o[gi*DATA_W +: DATA_W] = data;
    assign rd_perr_o[gi]                  = perr;
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed testbench for regfile_mp: default, no-bypass and small 4-port instances.
module tb_regfile_mp;

  logic        clk;
  logic        rst;
  logic        clear;
  logic [9:0]  rd_addr;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic [63:0] rd_data, rd_data_nb;
  logic [1:0]  perr, perr_nb;
  logic        ready, ready_nb;
  logic [7:0]  led, led_nb;

  logic         s_rst;
  logic         s_clear;
  logic [11:0]  s_rd_addr;
  logic         s_wr_en;
  logic [2:0]   s_wr_addr;
  logic [31:0]  s_wr_data;
  logic [127:0] s_rd_data;
  logic [3:0]   s_perr;
  logic         s_ready;
  logic [7:0]   s_led;

  int errors = 0;
  int checks = 0;

  regfile_mp dut (
    .clk(clk), .rst(rst), .clear_i(clear), .rd_addr_i(rd_addr), .rd_data_o(rd_data),
    .rd_perr_o(perr), .wr_en_i(wr_en), .wr_addr_i(wr_addr), .wr_data_i(wr_data),
    .ready_o(ready), .led_o(led)
  );

  regfile_mp #(.BYPASS(0)) dut_nb (
    .clk(clk), .rst(rst), .clear_i(clear), .rd_addr_i(rd_addr), .rd_data_o(rd_data_nb),
    .rd_perr_o(perr_nb), .wr_en_i(wr_en), .wr_addr_i(wr_addr), .wr_data_i(wr_data),
    .ready_o(ready_nb), .led_o(led_nb)
  );

  regfile_mp #(.ADDR_W(3), .NUM_RD(4)) dut_s (
    .clk(clk), .rst(s_rst), .clear_i(s_clear), .rd_addr_i(s_rd_addr), .rd_data_o(s_rd_data),
    .rd_perr_o(s_perr), .wr_en_i(s_wr_en), .wr_addr_i(s_wr_addr), .wr_data_i(s_wr_data),
    .ready_o(s_ready), .led_o(s_led)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write1(input logic [4:0] a, input logic [31:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    checks++;
    if (ready !== 1'b0 || led !== 8'h00 || perr !== 2'b00) begin
      errors++;
      $display("FAIL reset_state: ready=%b led=%h perr=%b required 0/00/00", ready, led, perr);
    end
    rst = 1'b0;
    for (int k = 1; k <= 32; k++) begin
      rd_addr = {5'(k), 5'(31 - k)};
      #1;
      checks++;
      if (ready !== 1'b0 || rd_data !== 64'h0) begin
        errors++;
        $display("FAIL reset_clear cycle %0d: ready=%b rd=%h required 0/0", k, ready, rd_data);
      end
      tick();
    end
    checks++;
    if (ready !== 1'b1 || ready_nb !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready: ready=%b/%b required 1", ready, ready_nb);
    end
    $display("reset: ready after 32 clocks, led=%h", led);
  endtask

  task automatic test_write_read();
    write1(5'd5, 32'hDEADBEEF);
    rd_addr = {5'd5, 5'd5};
    #1;
    checks++;
    if (rd_data !== {32'hDEADBEEF, 32'hDEADBEEF} || led !== 8'hEF) begin
      errors++;
      $display("FAIL write_read_r5: rd=%h led=%h required DEADBEEFDEADBEEF/EF", rd_data, led);
    end
    wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'h12345678; rd_addr = {5'd0, 5'd0};
    #1;
    checks++;
    if (rd_data !== 64'h0) begin
      errors++;
      $display("FAIL zero_bypass: rd=%h required 0", rd_data);
    end
    tick();
    wr_en = 1'b0;
    #1;
    checks++;
    if (rd_data !== 64'h0 || led !== 8'hEF) begin
      errors++;
      $display("FAIL zero_write: rd=%h led=%h required 0/EF", rd_data, led);
    end
    $display("write_read: r5=%h led=%h", rd_data, led);
  endtask

  task automatic test_bypass();
    wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'hA5A5A5A5; rd_addr = {5'd7, 5'd5};
    #1;
    checks++;
    if (rd_data !== {32'hA5A5A5A5, 32'hDEADBEEF}) begin
      errors++;
      $display("FAIL bypass_on: rd=%h required A5A5A5A5DEADBEEF", rd_data);
    end
    checks++;
    if (rd_data_nb !== {32'h0, 32'hDEADBEEF}) begin
      errors++;
      $display("FAIL bypass_off_same: rd=%h required 00000000DEADBEEF", rd_data_nb);
    end
    tick();
    wr_en = 1'b0;
    #1;
    checks++;
    if (rd_data_nb !== {32'hA5A5A5A5, 32'hDEADBEEF} || rd_data !== rd_data_nb) begin
      errors++;
      $display("FAIL bypass_off_next: rd_nb=%h rd=%h required A5A5A5A5DEADBEEF", rd_data_nb, rd_data);
    end
    $display("bypass: r7=%h", rd_data[63:32]);
  endtask

  task automatic test_clear();
    for (int i = 1; i < 32; i++) write1(5'(i), 32'(i));
    rd_addr = {5'd31, 5'd3};
    #1;
    checks++;
    if (rd_data !== {32'd31, 32'd3}) begin
      errors++;
      $display("FAIL fill: rd=%h required 0000001F00000003", rd_data);
    end
    clear = 1'b1; wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'h0000FFFF;
    #1;
    checks++;
    if (rd_data !== {32'd31, 32'd3}) begin
      errors++;
      $display("FAIL clear_drop_bypass: rd=%h required 0000001F00000003", rd_data);
    end
    tick();
    clear = 1'b0; wr_en = 1'b0;
    checks++;
    if (ready !== 1'b0) begin
      errors++;
      $display("FAIL clear_ready_low: ready=%b required 0", ready);
    end
    for (int k = 1; k <= 32; k++) begin
      tick();
      checks++;
      if (ready !== (k == 32)) begin
        errors++;
        $display("FAIL clear_ready tick %0d: ready=%b required %b", k, ready, (k == 32));
      end
    end
    for (int a = 0; a < 32; a += 2) begin
      rd_addr = {5'(a + 1), 5'(a)};
      #1;
      checks++;
      if (rd_data !== 64'h0) begin
        errors++;
        $display("FAIL cleared r%0d/r%0d: rd=%h required 0", a, a + 1, rd_data);
      end
    end
    checks++;
    if (led !== 8'h1F) begin
      errors++;
      $display("FAIL clear_led: led=%h required 1F", led);
    end
    $display("clear: all entries 0, led=%h", led);
  endtask

  task automatic test_rst_mid();
    write1(5'd4, 32'h44);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    repeat (10) tick();
    checks++;
    if (dut.u_clr.clr_ptr_q !== 5'd10) begin
      errors++;
      $display("FAIL mid_ptr: clr_ptr=%0d required 10", dut.u_clr.clr_ptr_q);
    end
    rst = 1'b1;
    tick();
    checks++;
    if (dut.u_clr.clr_ptr_q !== 5'd0 || ready !== 1'b0 || led !== 8'h00) begin
      errors++;
      $display("FAIL mid_rst: clr_ptr=%0d ready=%b led=%h required 0/0/00",
               dut.u_clr.clr_ptr_q, ready, led);
    end
    rst = 1'b0;
    for (int k = 1; k <= 32; k++) begin
      tick();
      checks++;
      if (ready !== (k == 32)) begin
        errors++;
        $display("FAIL mid_ready tick %0d: ready=%b required %b", k, ready, (k == 32));
      end
    end
    rd_addr = {5'd4, 5'd4};
    #1;
    checks++;
    if (rd_data !== 64'h0) begin
      errors++;
      $display("FAIL mid_r4: rd=%h required 0", rd_data);
    end
    $display("rst_mid: ready after 32 clocks");
  endtask

  task automatic test_small();
    s_rst = 1'b1;
    repeat (2) tick();
    s_rst = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      tick();
      checks++;
      if (s_ready !== (k == 8)) begin
        errors++;
        $display("FAIL small_ready tick %0d: ready=%b required %b", k, s_ready, (k == 8));
      end
    end
    for (int i = 1; i < 8; i++) begin
      s_wr_en = 1'b1; s_wr_addr = 3'(i); s_wr_data = 32'h100 + 32'(i);
      tick();
    end
    s_wr_en = 1'b0;
    s_rd_addr = {3'd7, 3'd0, 3'd2, 3'd2};
    #1;
    checks++;
    if (s_rd_data !== {32'h107, 32'h0, 32'h102, 32'h102}) begin
      errors++;
      $display("FAIL small_read_a: rd=%h required 00000107000000000000010200000102", s_rd_data);
    end
    s_rd_addr = {3'd1, 3'd6, 3'd4, 3'd3};
    #1;
    checks++;
    if (s_rd_data !== {32'h101, 32'h106, 32'h104, 32'h103} || s_led !== 8'h07) begin
      errors++;
      $display("FAIL small_read_b: rd=%h led=%h required 00000101000001060000010400000103/07",
               s_rd_data, s_led);
    end
    $display("small: 4-port reads rd=%h", s_rd_data);
  endtask

`ifdef REGFILE_PARITY_EN
  task automatic test_parity();
    write1(5'd9, 32'h0F0F0001);
    write1(5'd4, 32'h00000444);
    dut.mem_q[9][0] = ~dut.mem_q[9][0];
    rd_addr = {5'd9, 5'd4};
    #1;
    checks++;
    if (perr !== 2'b10) begin
      errors++;
      $display("FAIL parity_one_port: perr=%b required 10", perr);
    end
    rd_addr = {5'd9, 5'd9};
    #1;
    checks++;
    if (perr !== 2'b11) begin
      errors++;
      $display("FAIL parity_both: perr=%b required 11", perr);
    end
    wr_en = 1'b1; wr_addr = 5'd9; wr_data = 32'h00000007;
    #1;
    checks++;
    if (perr !== 2'b00) begin
      errors++;
      $display("FAIL parity_bypass: perr=%b required 00", perr);
    end
    tick();
    wr_en = 1'b0;
    #1;
    checks++;
    if (perr !== 2'b00 || rd_data !== {32'h7, 32'h7}) begin
      errors++;
      $display("FAIL parity_rewrite: perr=%b rd=%h required 00/0000000700000007", perr, rd_data);
    end
    $display("parity: perr=%b", perr);
  endtask
`endif

  initial begin
    rst = 1'b1; clear = 1'b0; rd_addr = '0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    s_rst = 1'b1; s_clear = 1'b0; s_rd_addr = '0; s_wr_en = 1'b0; s_wr_addr = '0; s_wr_data = '0;
    #1;
    test_reset();
    test_write_read();
    test_bypass();
    test_clear();
    test_rst_mid();
    test_small();
`ifdef REGFILE_PARITY_EN
    test_parity();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
